// File: rtl/game_pkg.sv
// Shared types, route tables and helpers for the game player and its bench.
// Routes are stored as direction lists; the player walks them by move index.
package game_pkg;

    typedef enum logic [1:0] {N, S, E, W} dir_e;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        WON     = 2'b01,
        DEAD    = 2'b10,
        TIMEOUT = 2'b11
    } result_e;

    typedef enum logic [2:0] {
        IDLE,
        GRST,
        GAP,
        MOVE,
        WAIT_END,
        DONE
    } player_state_e;

    localparam dir_e ROUTE0 [5] = '{E, S, W, E, E};
    localparam dir_e ROUTE1 [3] = '{E, S, E};

    localparam int WAIT_END_LIMIT = 4;

    function automatic logic [3:0] route_len(input logic route);
        return route ? 4'($size(ROUTE1)) : 4'($size(ROUTE0));
    endfunction

    // Out-of-range indices fall back to E; the player never issues them.
    function automatic dir_e route_dir(input logic route, input logic [3:0] idx);
        dir_e dir;
        dir = E;
        if (route) begin
            if (idx < 4'd3) dir = ROUTE1[idx[1:0]];
        end else begin
            if (idx < 4'd5) dir = ROUTE0[idx[2:0]];
        end
        return dir;
    endfunction

    // Packed as {n, s, e, w}.
    function automatic logic [3:0] dir_onehot(input dir_e dir);
        logic [3:0] oh;
        oh = 4'b0000;
        case (dir)
            N: oh = 4'b1000;
            S: oh = 4'b0100;
            E: oh = 4'b0010;
            W: oh = 4'b0001;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/game_player_if.sv
// Host/game-facing signal bundle of the game player.
// The player sits on the slave side; the host and game sit on the master side.
interface game_player_if;
    import game_pkg::*;

    logic       start;
    logic       route_sel;
    logic [3:0] gap;
    logic       win;
    logic       d;
    logic       n;
    logic       s;
    logic       e;
    logic       w;
    logic       game_R;
    logic       busy;
    logic       done;
    result_e    result;
    logic [3:0] moves;

    modport master (
        output start, route_sel, gap, win, d,
        input  n, s, e, w, game_R, busy, done, result, moves
    );

    modport slave (
        input  start, route_sel, gap, win, d,
        output n, s, e, w, game_R, busy, done, result, moves
    );

endinterface

// File: rtl/gap_timer.sv
// Down-counter that times the idle cycles between moves.
// Held loaded while idle; counts toward zero once enabled.
module gap_timer (
    input  logic       clock,
    input  logic       R_n,
    input  logic       load,
    input  logic       count,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clock or negedge R_n) begin
        if (!R_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/game_player.sv
// Automated player: resets the game, walks a fixed route with optional gaps
// between moves, then reports how the game ended.
module game_player
    import game_pkg::*;
(
    input  logic         clock,
    input  logic         R_n,
    game_player_if.slave bus
);

    localparam logic [1:0] WAIT_LAST = 2'(WAIT_END_LIMIT - 1);

    player_state_e state;
    logic          route_q;
    logic [3:0]    gap_q;
    logic [1:0]    wait_cnt;
    logic [3:0]    moves_q;
    result_e       result_q;
    logic [3:0]    dir_q;
    logic          game_r_q;
    logic          busy_q;
    logic          done_q;

    result_e       end_res;
    logic [3:0]    moves_nxt;
    logic          last_move;
    logic          timer_zero;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it holding a value (no latch).
    always_comb begin
        end_res = NONE;
        if (bus.win)    end_res = WON;
        else if (bus.d) end_res = DEAD;
        moves_nxt = moves_q + 4'd1;
        last_move = (moves_nxt == route_len(route_q));
    end

    // Loads gap-1 outside GAP so that zero marks the final GAP cycle.
    gap_timer u_gap_timer (
        .clock    (clock),
        .R_n      (R_n),
        .load     (state != GAP),
        .count    (state == GAP),
        .load_val (gap_q - 4'd1),
        .zero     (timer_zero)
    );

    // NOTE: state and outputs use non-blocking assignments; the pulse defaults at the top are overridden later in the same block.
    always_ff @(posedge clock or negedge R_n) begin
        if (!R_n) begin
            state    <= IDLE;
            route_q  <= 1'b0;
            gap_q    <= 4'd0;
            wait_cnt <= 2'd0;
            moves_q  <= 4'd0;
            result_q <= NONE;
            dir_q    <= 4'b0000;
            game_r_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            game_r_q <= 1'b0;
            done_q   <= 1'b0;
            dir_q    <= 4'b0000;

            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        route_q  <= bus.route_sel;
                        gap_q    <= bus.gap;
                        moves_q  <= 4'd0;
                        result_q <= NONE;
                        game_r_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= GRST;
                    end
                end

                GRST: begin
                    if (gap_q != 4'd0) begin
                        state <= GAP;
                    end else begin
                        state <= MOVE;
                        dir_q <= dir_onehot(route_dir(route_q, moves_q));
                    end
                end

                GAP: begin
                    if (end_res != NONE) begin
                        result_q <= end_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else if (timer_zero) begin
                        state <= MOVE;
                        dir_q <= dir_onehot(route_dir(route_q, moves_q));
                    end
                end

                MOVE: begin
                    moves_q <= moves_nxt;
                    if (end_res != NONE) begin
                        result_q <= end_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else if (last_move) begin
                        wait_cnt <= 2'd0;
                        state    <= WAIT_END;
                    end else if (gap_q != 4'd0) begin
                        state <= GAP;
                    end else begin
                        dir_q <= dir_onehot(route_dir(route_q, moves_nxt));
                    end
                end

                WAIT_END: begin
                    if (end_res != NONE) begin
                        result_q <= end_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        result_q <= TIMEOUT;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end

                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.n      = dir_q[3];
    assign bus.s      = dir_q[2];
    assign bus.e      = dir_q[1];
    assign bus.w      = dir_q[0];
    assign bus.game_R = game_r_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.moves  = moves_q;

endmodule

// File: tb/tb_game_player.sv
// Bench for game_player: a small game model answers the moves, a scoreboard
// holds the expected move stream, and a vector table drives whole runs.
module tb_game_player;
    import game_pkg::*;

    logic clock;
    logic R_n;

    game_player_if bus ();

    game_player dut (
        .clock (clock),
        .R_n   (R_n),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Game model modes: 0 normal, 1 silent, 2 trap on first move, 3 win and dead together.
    int game_mode = 0;

    function automatic byte ref_move(input int route, input int idx);
        string r0 = "ESWEE";
        string r1 = "ESE";
        if (route == 0) return (idx >= 0 && idx < 5) ? r0[idx] : 8'd0;
        return (idx >= 0 && idx < 3) ? r1[idx] : 8'd0;
    endfunction

    byte        mv;
    logic [2:0] g_cnt;
    logic       g_ok0, g_ok1, g_win_pos, g_dead_pos;
    logic       hit0, hit1;

    always_comb begin
        mv = 8'd0;
        if (bus.n)      mv = byte'("N");
        else if (bus.s) mv = byte'("S");
        else if (bus.e) mv = byte'("E");
        else if (bus.w) mv = byte'("W");
        hit0 = g_ok0 && (mv == ref_move(0, int'(g_cnt)));
        hit1 = g_ok1 && (mv == ref_move(1, int'(g_cnt)));
    end

    // Position settles one cycle after a move, status one cycle after that.
    always @(posedge clock or negedge R_n) begin
        if (!R_n || bus.game_R) begin
            g_cnt      <= 3'd0;
            g_ok0      <= 1'b1;
            g_ok1      <= 1'b1;
            g_win_pos  <= 1'b0;
            g_dead_pos <= 1'b0;
            bus.win    <= 1'b0;
            bus.d      <= 1'b0;
        end else begin
            bus.win <= (game_mode != 1) && g_win_pos;
            bus.d   <= (game_mode != 1) && g_dead_pos;
            if (mv != 8'd0) begin
                g_cnt      <= g_cnt + 3'd1;
                g_ok0      <= hit0;
                g_ok1      <= hit1;
                g_win_pos  <= hit0 && (g_cnt == 3'd4);
                g_dead_pos <= (hit1 && g_cnt == 3'd2) ||
                              (game_mode == 2 && g_cnt == 3'd0) ||
                              (game_mode == 3 && hit0 && g_cnt == 3'd4);
            end
        end
    end

    typedef struct {
        int route;
        int gap;
        int mode;
        int pester;
        int exp_result;
        int exp_moves;
        int exp_done;
    } vec_t;

    typedef struct {
        byte dir;
        int  cyc;
    } move_t;

    move_t sb[$];
    vec_t  vecs[10];

    task automatic run_vec(input vec_t v, input string tag);
        int    cyc;
        int    done_cyc;
        int    res;
        int    mvs;
        int    busy_bad;
        int    grst_cnt;
        int    ones;
        bit    seen_done;
        move_t m;

        game_mode = v.mode;
        sb.delete();
        for (int k = 0; k < v.exp_moves; k++) begin
            m.dir = ref_move(v.route, k);
            m.cyc = 2 + v.gap + k * (v.gap + 1);
            sb.push_back(m);
        end

        @(negedge clock);
        bus.start     = 1'b1;
        bus.route_sel = v.route[0];
        bus.gap       = v.gap[3:0];
        @(negedge clock);
        bus.start     = 1'b0;
        bus.route_sel = ~v.route[0];
        bus.gap       = v.gap[3:0] + 4'd5;

        cyc       = 1;
        seen_done = 0;
        done_cyc  = -1;
        res       = -1;
        mvs       = -1;
        busy_bad  = 0;
        grst_cnt  = 0;
        check({tag, "_game_R_c1"}, int'(bus.game_R), 1);
        check({tag, "_result_cleared"}, int'(bus.result), 0);
        check({tag, "_moves_cleared"}, int'(bus.moves), 0);

        while (!seen_done && cyc < 120) begin
            if (v.pester != 0 && cyc >= 3 && cyc <= 6) begin
                bus.start     = 1'b1;
                bus.route_sel = 1'b1;
                bus.gap       = 4'd7;
            end else begin
                bus.start = 1'b0;
            end
            if (!bus.busy) busy_bad++;
            if (bus.game_R) grst_cnt++;
            ones = $countones({bus.n, bus.s, bus.e, bus.w});
            if (ones > 1) check({tag, "_onehot"}, ones, 1);
            if (mv != 8'd0) begin
                if (sb.size() == 0) begin
                    check({tag, "_extra_move_cycle"}, cyc, -1);
                end else begin
                    m = sb.pop_front();
                    check({tag, "_move_dir"}, int'(mv), int'(m.dir));
                    check({tag, "_move_cycle"}, cyc, m.cyc);
                end
            end
            if (bus.done) begin
                seen_done = 1;
                done_cyc  = cyc;
                res       = int'(bus.result);
                mvs       = int'(bus.moves);
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        bus.start = 1'b0;

        check({tag, "_done_seen"}, int'(seen_done), 1);
        check({tag, "_done_cycle"}, done_cyc, v.exp_done);
        check({tag, "_result"}, res, v.exp_result);
        check({tag, "_moves"}, mvs, v.exp_moves);
        check({tag, "_moves_left"}, sb.size(), 0);
        check({tag, "_busy_gaps"}, busy_bad, 0);
        check({tag, "_game_R_pulses"}, grst_cnt, 1);

        @(negedge clock);
        check({tag, "_done_one_cycle"}, int'(bus.done), 0);
        check({tag, "_idle_busy"}, int'(bus.busy), 0);
        repeat (3) @(negedge clock);
        check({tag, "_result_hold"}, int'(bus.result), v.exp_result);
        check({tag, "_moves_hold"}, int'(bus.moves), v.exp_moves);
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;

        vecs[0] = '{0,  0, 0, 0, 1, 5,  9};
        vecs[1] = '{1,  0, 0, 0, 2, 3,  7};
        vecs[2] = '{0,  2, 0, 0, 1, 5, 19};
        vecs[3] = '{0,  0, 1, 0, 3, 5, 11};
        vecs[4] = '{1,  1, 1, 0, 3, 3, 12};
        vecs[5] = '{0,  3, 2, 0, 2, 1,  8};
        vecs[6] = '{0,  0, 2, 0, 2, 3,  5};
        vecs[7] = '{0,  0, 3, 0, 1, 5,  9};
        vecs[8] = '{1, 15, 0, 0, 2, 3, 52};
        vecs[9] = '{0,  0, 0, 1, 1, 5,  9};

        R_n           = 1'b0;
        bus.start     = 1'b0;
        bus.route_sel = 1'b0;
        bus.gap       = 4'd0;
        repeat (2) @(negedge clock);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_game_R", int'(bus.game_R), 0);
        check("rst_dirs", int'({bus.n, bus.s, bus.e, bus.w}), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_moves", int'(bus.moves), 0);
        R_n = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted mid-run, during the third move.
        game_mode = 0;
        @(negedge clock);
        bus.start     = 1'b1;
        bus.route_sel = 1'b0;
        bus.gap       = 4'd0;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        check("midrst_pre_move_w", int'(bus.w), 1);
        check("midrst_pre_busy", int'(bus.busy), 1);
        R_n = 1'b0;
        #1;
        check("midrst_dirs", int'({bus.n, bus.s, bus.e, bus.w}), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_game_R", int'(bus.game_R), 0);
        check("midrst_result", int'(bus.result), 0);
        check("midrst_moves", int'(bus.moves), 0);
        repeat (2) @(negedge clock);
        R_n      = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_stays_idle", busy_cnt, 0);

        run_vec(vecs[1], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
